input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the consecutive stable cycles needed to accept a button change (legal range 2..1048575).
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 Port btn_n  input  4  raw active-low pushbuttons, asynchronous to clk; btn_n[0] is the light-gun trigger.
REQ-005 Port sw  input  10  raw slide switches, asynchronous to clk.
REQ-006 Port evt_clr  input  4  per-bit clear of sticky press events, driven from processor output-device bits.
REQ-007 Port cnt_clr  input  1  clears trigger count and overflow flag.
REQ-008 Port in_devices  output  32  registered status word, consumed as the processor input-device word.

Function
REQ-009 Each btn_n and sw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 in_devices field map SHALL be: [3:0] debounced button levels (1 = pressed); [7:4] sticky press events; [17:8] synchronized switches; [25:18] trigger press count; [26] count overflow; [31:27] constant 0.
REQ-011 Each button SHALL have a 20-bit counter: cleared when synchronized level equals debounced level; incremented while they differ.
REQ-012 When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced level SHALL take the synchronized level and the counter SHALL clear in the same cycle.
REQ-013 A mismatch shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level unchanged (glitch rejection).
REQ-014 A press event SHALL be a 0->1 transition of a debounced level; releases SHALL generate no event.
REQ-015 A sticky event bit SHALL set on its press event and clear on evt_clr of the same bit; on simultaneous set and clear, set SHALL win.
REQ-016 The trigger count SHALL increment by 1 on each button-0 press event and saturate at 255.
REQ-017 A button-0 press event while the count is 255 SHALL set overflow; overflow SHALL stay set until cnt_clr.
REQ-018 cnt_clr SHALL zero count and overflow; a simultaneous button-0 press event SHALL yield count = 1, overflow = 0.
REQ-019 in_devices SHALL be fully registered; latency from a raw button change held steady to field [3:0] SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles, and from a switch change to [17:8] SHALL be 3 cycles.
REQ-020 Sticky event and count fields SHALL update on the same output edge as the debounced level that caused them.

Reset
REQ-021 While reset = 0, synchronizers, counters, debounced levels (released), sticky events, count, overflow and in_devices SHALL all be 0.
REQ-022 Assertion mid-debounce SHALL discard the partial count; after release no press event SHALL fire unless a button is newly held for DEBOUNCE_CYCLES.
REQ-023 A button already held at reset release SHALL be reported as a press after the normal debounce latency.

Configuration
REQ-024 With macro INPUT_DEBOUNCE_EN defined, buttons SHALL be debounced per REQ-011..REQ-013.
REQ-025 Without INPUT_DEBOUNCE_EN, the debounce counters SHALL be omitted and the debounced level SHALL equal the synchronized level, delayed one register (button latency 3 cycles); all other behaviour SHALL be unchanged.

Verification
REQ-026 DEBOUNCE_CYCLES = 4, INPUT_DEBOUNCE_EN defined: btn_n[0] 1->0 held -> in_devices[0] = 1, [4] = 1 and [25:18] = 1 exactly 7 cycles after the change.
REQ-027 btn_n[2] pulsed low for 3 cycles -> in_devices[2], [6] stay 0 throughout.
REQ-028 256 debounced trigger presses -> count reads 255, [26] = 0 after press 255 and [26] = 1 after press 256; then cnt_clr -> count 0, overflow 0.
REQ-029 evt_clr[1] asserted on the same cycle a button-1 press event is registered -> in_devices[5] = 1; evt_clr[1] one cycle later -> [5] = 0.
REQ-030 sw = 10'h2A5 applied -> in_devices[17:8] = 10'h2A5 after 3 cycles; reset pulsed low mid-debounce of button 3 -> in_devices = 0 immediately, with no spurious event after release.
REQ-031 INPUT_DEBOUNCE_EN undefined: btn_n[3] low for 1 cycle -> in_devices[3] = 1 and [7] = 1 three cycles later.

Source files
------------

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - button/switch synchronizer, debouncer, sticky events and trigger counter.
// Define INPUT_DEBOUNCE_EN to debounce buttons; otherwise the synchronized level is used directly.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn_n,
  input  logic [9:0]  sw,
  input  logic [3:0]  evt_clr,
  input  logic        cnt_clr,
  output logic [31:0] in_devices
);

  // Buttons are inverted on entry so that every reset value of 0 means "released".
  logic [3:0] btn_meta;
  logic [3:0] btn_sync;
  logic [9:0] sw_meta;
  logic [9:0] sw_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= 4'b0;
      btn_sync <= 4'b0;
      sw_meta  <= 10'b0;
      sw_sync  <= 10'b0;
    end else begin
      btn_meta <= ~btn_n;
      btn_sync <= btn_meta;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

  logic [3:0] btn_db;

`ifdef INPUT_DEBOUNCE_EN
  localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

  logic [3:0][19:0] db_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt <= '0;
      btn_db <= 4'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_sync[i] == btn_db[i]) begin
          db_cnt[i] <= 20'd0;
        end else if (db_cnt[i] == CNT_MAX) begin
          btn_db[i] <= btn_sync[i];
          db_cnt[i] <= 20'd0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end
`else
  assign btn_db = btn_sync;
`endif

  // The output register doubles as the previous-level store for edge detection,
  // so level, sticky event and count all change on the same edge.
  logic [3:0] lvl_q;
  logic [3:0] sticky_q;
  logic [9:0] sw_q;
  logic [7:0] count_q;
  logic       ovf_q;
  logic [3:0] press;

  assign press = btn_db & ~lvl_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_q    <= 4'b0;
      sticky_q <= 4'b0;
      sw_q     <= 10'b0;
      count_q  <= 8'd0;
      ovf_q    <= 1'b0;
    end else begin
      lvl_q    <= btn_db;
      sticky_q <= (sticky_q & ~evt_clr) | press;
      sw_q     <= sw_sync;
      if (cnt_clr) begin
        count_q <= press[0] ? 8'd1 : 8'd0;
        ovf_q   <= 1'b0;
      end else if (press[0]) begin
        if (count_q == 8'hFF) begin
          ovf_q <= 1'b1;
        end else begin
          count_q <= count_q + 8'd1;
        end
      end
    end
  end

  assign in_devices = {5'b0, ovf_q, count_q, sw_q, sticky_q, lvl_q};

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner.
module tb_input_conditioner;

  localparam int D = 4;
`ifdef INPUT_DEBOUNCE_EN
  localparam int LAT = D + 3;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  btn_n;
  logic [9:0]  sw;
  logic [3:0]  evt_clr;
  logic        cnt_clr;
  logic [31:0] in_devices;

  int checks = 0;
  int errors = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_n      (btn_n),
    .sw         (sw),
    .evt_clr    (evt_clr),
    .cnt_clr    (cnt_clr),
    .in_devices (in_devices)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_btn0;
    btn_n[0] = 1'b0;
    tick(LAT + 1);
    btn_n[0] = 1'b1;
    tick(LAT + 1);
  endtask

  task automatic test_reset;
    reset = 1'b0; btn_n = 4'hF; sw = 10'h3FF; evt_clr = 4'h0; cnt_clr = 1'b0;
    tick(3);
    checks++;
    if (in_devices !== 32'h0) begin
      errors++; $display("FAIL reset_hold got %h want 00000000", in_devices);
    end
    sw = 10'h0;
    tick(1);
    reset = 1'b1;
    tick(4);
    checks++;
    if (in_devices !== 32'h0) begin
      errors++; $display("FAIL reset_idle got %h want 00000000", in_devices);
    end
  endtask

  task automatic test_switch;
    sw = 10'h2A5;
    tick(2);
    checks++;
    if (in_devices[17:8] !== 10'h000) begin
      errors++; $display("FAIL sw_early got %h want 000", in_devices[17:8]);
    end
    tick(1);
    checks++;
    if (in_devices[17:8] !== 10'h2A5) begin
      errors++; $display("FAIL sw_2a5 got %h want 2a5", in_devices[17:8]);
    end
    sw = 10'h15A;
    tick(3);
    checks++;
    if (in_devices[17:8] !== 10'h15A) begin
      errors++; $display("FAIL sw_15a got %h want 15a", in_devices[17:8]);
    end
    sw = 10'h2A5;
    tick(3);
  endtask

  task automatic test_trigger;
    btn_n[0] = 1'b0;
    tick(LAT - 1);
    checks++;
    if (in_devices[0] !== 1'b0 || in_devices[4] !== 1'b0) begin
      errors++; $display("FAIL trig_early got lvl=%b evt=%b want 0 0", in_devices[0], in_devices[4]);
    end
    tick(1);
    checks++;
    if (in_devices[0] !== 1'b1 || in_devices[4] !== 1'b1 || in_devices[25:18] !== 8'd1) begin
      errors++; $display("FAIL trig_press got lvl=%b evt=%b cnt=%0d want 1 1 1",
                         in_devices[0], in_devices[4], in_devices[25:18]);
    end
    btn_n[0] = 1'b1;
    tick(LAT + 1);
    checks++;
    if (in_devices[0] !== 1'b0 || in_devices[4] !== 1'b1 || in_devices[25:18] !== 8'd1) begin
      errors++; $display("FAIL trig_release got lvl=%b evt=%b cnt=%0d want 0 1 1",
                         in_devices[0], in_devices[4], in_devices[25:18]);
    end
  endtask

  task automatic test_glitch;
    btn_n[2] = 1'b0;
    tick(3);
    btn_n[2] = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      tick(1);
      checks++;
      if (in_devices[2] !== 1'b0 || in_devices[6] !== 1'b0) begin
        errors++; $display("FAIL glitch cycle %0d got lvl=%b evt=%b want 0 0", i, in_devices[2], in_devices[6]);
      end
    end
  endtask

  task automatic test_pulse;
    btn_n[3] = 1'b0;
    tick(1);
    btn_n[3] = 1'b1;
    tick(2);
    checks++;
    if (in_devices[3] !== 1'b1 || in_devices[7] !== 1'b1) begin
      errors++; $display("FAIL pulse_press got lvl=%b evt=%b want 1 1", in_devices[3], in_devices[7]);
    end
    tick(1);
    checks++;
    if (in_devices[3] !== 1'b0 || in_devices[7] !== 1'b1) begin
      errors++; $display("FAIL pulse_release got lvl=%b evt=%b want 0 1", in_devices[3], in_devices[7]);
    end
    evt_clr = 4'b1000;
    tick(1);
    evt_clr = 4'b0000;
    checks++;
    if (in_devices[7] !== 1'b0) begin
      errors++; $display("FAIL pulse_clr got evt=%b want 0", in_devices[7]);
    end
  endtask

  task automatic test_sticky_clear;
    btn_n[1] = 1'b0;
    tick(LAT - 1);
    evt_clr = 4'b0010;
    tick(1);
    evt_clr = 4'b0000;
    checks++;
    if (in_devices[1] !== 1'b1 || in_devices[5] !== 1'b1) begin
      errors++; $display("FAIL sticky_set_wins got lvl=%b evt=%b want 1 1", in_devices[1], in_devices[5]);
    end
    evt_clr = 4'b0010;
    tick(1);
    evt_clr = 4'b0000;
    checks++;
    if (in_devices[5] !== 1'b0 || in_devices[4] !== 1'b1) begin
      errors++; $display("FAIL sticky_clr1 got evt1=%b evt0=%b want 0 1", in_devices[5], in_devices[4]);
    end
    evt_clr = 4'b0001;
    tick(1);
    evt_clr = 4'b0000;
    checks++;
    if (in_devices[4] !== 1'b0 || in_devices[1] !== 1'b1) begin
      errors++; $display("FAIL sticky_clr0 got evt0=%b lvl1=%b want 0 1", in_devices[4], in_devices[1]);
    end
    btn_n[1] = 1'b1;
    tick(LAT + 1);
  endtask

  task automatic test_count_saturation;
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    checks++;
    if (in_devices[25:18] !== 8'd0 || in_devices[26] !== 1'b0) begin
      errors++; $display("FAIL cnt_clear got cnt=%0d ovf=%b want 0 0", in_devices[25:18], in_devices[26]);
    end
    press_btn0();
    checks++;
    if (in_devices[25:18] !== 8'd1) begin
      errors++; $display("FAIL cnt_one got %0d want 1", in_devices[25:18]);
    end
    for (int i = 0; i < 253; i++) press_btn0();
    checks++;
    if (in_devices[25:18] !== 8'd254 || in_devices[26] !== 1'b0) begin
      errors++; $display("FAIL cnt_254 got cnt=%0d ovf=%b want 254 0", in_devices[25:18], in_devices[26]);
    end
    press_btn0();
    checks++;
    if (in_devices[25:18] !== 8'd255 || in_devices[26] !== 1'b0) begin
      errors++; $display("FAIL cnt_255 got cnt=%0d ovf=%b want 255 0", in_devices[25:18], in_devices[26]);
    end
    press_btn0();
    checks++;
    if (in_devices[25:18] !== 8'd255 || in_devices[26] !== 1'b1) begin
      errors++; $display("FAIL cnt_256 got cnt=%0d ovf=%b want 255 1", in_devices[25:18], in_devices[26]);
    end
    press_btn0();
    checks++;
    if (in_devices[25:18] !== 8'd255 || in_devices[26] !== 1'b1) begin
      errors++; $display("FAIL cnt_257 got cnt=%0d ovf=%b want 255 1", in_devices[25:18], in_devices[26]);
    end
    btn_n[0] = 1'b0;
    tick(LAT - 1);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    checks++;
    if (in_devices[25:18] !== 8'd1 || in_devices[26] !== 1'b0) begin
      errors++; $display("FAIL cnt_clr_press got cnt=%0d ovf=%b want 1 0", in_devices[25:18], in_devices[26]);
    end
    btn_n[0] = 1'b1;
    tick(LAT + 1);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    checks++;
    if (in_devices[25:18] !== 8'd0 || in_devices[26] !== 1'b0) begin
      errors++; $display("FAIL cnt_final_clr got cnt=%0d ovf=%b want 0 0", in_devices[25:18], in_devices[26]);
    end
  endtask

  task automatic test_reset_mid;
    btn_n[3] = 1'b0;
    tick(2);
    reset = 1'b0;
    #1;
    checks++;
    if (in_devices !== 32'h0) begin
      errors++; $display("FAIL reset_async got %h want 00000000", in_devices);
    end
    btn_n[3] = 1'b1;
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      tick(1);
      checks++;
      if (in_devices[3] !== 1'b0 || in_devices[7] !== 1'b0) begin
        errors++; $display("FAIL reset_spurious cycle %0d got lvl=%b evt=%b want 0 0", i, in_devices[3], in_devices[7]);
      end
    end
    checks++;
    if (in_devices[17:8] !== 10'h2A5) begin
      errors++; $display("FAIL reset_sw_restore got %h want 2a5", in_devices[17:8]);
    end
  endtask

  task automatic test_held_at_reset;
    btn_n[2] = 1'b0;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(LAT - 1);
    checks++;
    if (in_devices[2] !== 1'b0) begin
      errors++; $display("FAIL held_early got %b want 0", in_devices[2]);
    end
    tick(1);
    checks++;
    if (in_devices[2] !== 1'b1 || in_devices[6] !== 1'b1) begin
      errors++; $display("FAIL held_press got lvl=%b evt=%b want 1 1", in_devices[2], in_devices[6]);
    end
    btn_n[2] = 1'b1;
    tick(LAT + 1);
  endtask

  initial begin
    test_reset();
    test_switch();
    test_trigger();
`ifdef INPUT_DEBOUNCE_EN
    test_glitch();
`else
    test_pulse();
`endif
    test_sticky_clear();
    test_count_saturation();
    test_reset_mid();
    test_held_at_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
